// File: rtl/mem_mmio_unit_if.sv
// mem_mmio_unit_if
// Bundles the memory port and the peripheral pins of mem_mmio_unit.
//   adr        32  byte address from the core (word aligned)
//   writedata  32  store data from the core
//   memwrite    1  store strobe
//   readdata   32  combinational read data for adr
//   tx_data     8  console FIFO head byte
//   tx_valid    1  console FIFO non-empty
//   tx_ready    1  consumer accepts tx_data this cycle
//   gpio_out    8  GPIO register
//   irq         1  timer interrupt, level
// The master modport is the core/consumer side; the slave modport is the unit.
interface mem_mmio_unit_if;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] readdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  gpio_out;
  logic        irq;

  modport master (
    output adr, writedata, memwrite, tx_ready,
    input  readdata, tx_data, tx_valid, gpio_out, irq
  );

  modport slave (
    input  adr, writedata, memwrite, tx_ready,
    output readdata, tx_data, tx_valid, gpio_out, irq
  );
endinterface

// File: rtl/mem_mmio_unit.sv
// mem_mmio_unit
// Unified word RAM plus a small MMIO window for the multicycle core.
// adr[31]=0 selects RAM (aliased), adr[31]=1 selects MMIO register adr[4:2]:
//   0 CONSOLE_TX, 1 CONSOLE_STATUS, 2 CYCLE, 3 TIMER_CMP, 4 TIMER_CTRL, 5 GPIO.
// Ports:
//   clk    clock
//   reset  asynchronous, active-high
//   bus    mem_mmio_unit_if.slave (memory port, console handshake, gpio, irq)
// Build option: define MMIO_TIMER_EN to build the compare timer and irq;
// without it TIMER_CMP/TIMER_CTRL read 0 and irq is tied low.
module mem_mmio_unit #(
  parameter int    RAM_WORDS  = 64,
  parameter string INIT_FILE  = "memfile.dat",
  parameter int    FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  mem_mmio_unit_if.slave bus
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    REG_TX     = 3'd0,
    REG_STATUS = 3'd1,
    REG_CYCLE  = 3'd2,
    REG_CMP    = 3'd3,
    REG_CTRL   = 3'd4,
    REG_GPIO   = 3'd5,
    REG_RSV6   = 3'd6,
    REG_RSV7   = 3'd7
  } regIdx_t;

  logic [31:0]   ram [RAM_WORDS];
  logic [7:0]    fifoMem [FIFO_DEPTH];

  logic          isMmio;
  logic [AW-1:0] ramIdx;
  regIdx_t       regSel;
  logic          mmioWrite;
  logic          unusedAdrBits;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          fifoEmpty, fifoFull;
  logic          pushReq, pushAccept, pop;

  logic [31:0]   cycle_q;
  logic [7:0]    gpio_q;
  logic [31:0]   timerCmpRd;
  logic [31:0]   timerCtrlRd;

  assign isMmio        = bus.adr[31];
  assign ramIdx        = bus.adr[AW+1:2];
  assign regSel        = regIdx_t'(bus.adr[4:2]);
  assign mmioWrite     = bus.memwrite & isMmio;
  assign unusedAdrBits = ^bus.adr;

  assign fifoEmpty  = (count_q == '0);
  assign fifoFull   = (count_q == (PW+1)'(FIFO_DEPTH));
  assign pushReq    = mmioWrite && (regSel == REG_TX);
  assign pop        = !fifoEmpty && bus.tx_ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign pushAccept = pushReq && (!fifoFull || pop);

  // RAM store port; the RAM is deliberately outside reset so its contents survive it.
  always_ff @(posedge clk) begin
    if (bus.memwrite && !isMmio) ram[ramIdx] <= bus.writedata;
  end

  // FIFO storage is only qualified by the pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    if (pushAccept) fifoMem[tail_q] <= bus.writedata[7:0];
  end

  // Next-state for the FIFO pointers, occupancy and the sticky overflow flag.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (pop)        head_d = head_q + PW'(1);
    if (pushAccept) tail_d = tail_q + PW'(1);
    case ({pushAccept, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    if (pushReq && !pushAccept)                   ovf_d = 1'b1;
    else if (mmioWrite && (regSel == REG_STATUS)) ovf_d = 1'b0;
  end

  // Console FIFO state, cycle counter and GPIO register, all cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      cycle_q <= '0;
      gpio_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      cycle_q <= cycle_q + 32'd1;
      if (mmioWrite && (regSel == REG_GPIO)) gpio_q <= bus.writedata[7:0];
    end
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] cmp_q;
  logic        en_q;
  logic        pend_q, pend_d;

  // PEND is write-1-to-clear, but a match in the same cycle takes priority.
  always_comb begin
    pend_d = pend_q;
    if (mmioWrite && (regSel == REG_CTRL) && bus.writedata[1]) pend_d = 1'b0;
    if (en_q && (cycle_q == cmp_q)) pend_d = 1'b1;
  end

  // Timer registers; clearing EN leaves PEND alone so software can still see it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_q  <= '0;
      en_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      if (mmioWrite && (regSel == REG_CMP))  cmp_q <= bus.writedata;
      if (mmioWrite && (regSel == REG_CTRL)) en_q  <= bus.writedata[0];
      pend_q <= pend_d;
    end
  end

  assign timerCmpRd  = cmp_q;
  assign timerCtrlRd = {30'b0, pend_q, en_q};
  assign bus.irq     = en_q & pend_q;
`else
  assign timerCmpRd  = '0;
  assign timerCtrlRd = '0;
  assign bus.irq     = 1'b0;
`endif

  // Zero-latency read mux; the core samples readdata at the same edge it issues adr.
  always_comb begin
    bus.readdata = '0;
    if (!isMmio) begin
      bus.readdata = ram[ramIdx];
    end else begin
      case (regSel)
        REG_STATUS: bus.readdata = {29'b0, ovf_q, fifoFull, fifoEmpty};
        REG_CYCLE:  bus.readdata = cycle_q;
        REG_CMP:    bus.readdata = timerCmpRd;
        REG_CTRL:   bus.readdata = timerCtrlRd;
        REG_GPIO:   bus.readdata = {24'b0, gpio_q};
        default:    bus.readdata = '0;
      endcase
    end
  end

  assign bus.tx_data  = fifoMem[head_q];
  assign bus.tx_valid = !fifoEmpty;
  assign bus.gpio_out = gpio_q;

endmodule

// File: tb/tb_mem_mmio_unit.sv
// tb_mem_mmio_unit
// Directed plus randomized stimulus for mem_mmio_unit, checked against a
// behavioural model (word array, byte queue, plain counters) held in the bench.
// Honours MMIO_TIMER_EN the same way the design does.
module tb_mem_mmio_unit;

  localparam int RAM_WORDS  = 64;
  localparam int FIFO_DEPTH = 4;
`ifdef MMIO_TIMER_EN
  localparam bit TIMER_BUILT = 1'b1;
`else
  localparam bit TIMER_BUILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  mem_mmio_unit_if bus();

  mem_mmio_unit #(
    .RAM_WORDS (RAM_WORDS),
    .INIT_FILE (""),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mRam [RAM_WORDS];
  bit          mKnown [RAM_WORDS];
  logic [7:0]  mQ [$];
  bit          mOvf;
  logic [31:0] mCycle;
  logic [31:0] mCmp;
  bit          mEn;
  bit          mPend;
  logic [7:0]  mGpio;

  // Every comparison funnels through here so the counters stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int ramIndex(input logic [31:0] a);
    return int'((a >> 2) % RAM_WORDS);
  endfunction

  function automatic bit modelKnown(input logic [31:0] a);
    return a[31] || mKnown[ramIndex(a)];
  endfunction

  // Expected read value straight from the register map description.
  function automatic logic [31:0] modelRead(input logic [31:0] a);
    if (!a[31]) return mRam[ramIndex(a)];
    case (a[4:2])
      3'd1:    return {29'b0, mOvf, mQ.size() == FIFO_DEPTH, mQ.size() == 0};
      3'd2:    return mCycle;
      3'd3:    return TIMER_BUILT ? mCmp : 32'd0;
      3'd4:    return TIMER_BUILT ? {30'b0, mPend, mEn} : 32'd0;
      3'd5:    return {24'b0, mGpio};
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelReset();
    mQ.delete();
    mOvf   = 1'b0;
    mCycle = '0;
    mCmp   = '0;
    mEn    = 1'b0;
    mPend  = 1'b0;
    mGpio  = '0;
  endtask

  // Everything the model does at one rising edge, using pre-edge values.
  task automatic modelEdge(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic rdy);
    bit match;
    match = TIMER_BUILT && mEn && (mCycle == mCmp);
    if (mQ.size() != 0 && rdy) void'(mQ.pop_front());
    if (we) begin
      if (!a[31]) begin
        mRam[ramIndex(a)]   = wd;
        mKnown[ramIndex(a)] = 1'b1;
      end else begin
        case (a[4:2])
          3'd0: if (mQ.size() < FIFO_DEPTH) mQ.push_back(wd[7:0]); else mOvf = 1'b1;
          3'd1: mOvf = 1'b0;
          3'd3: if (TIMER_BUILT) mCmp = wd;
          3'd4: if (TIMER_BUILT) begin
                  mEn = wd[0];
                  if (wd[1]) mPend = 1'b0;
                end
          3'd5: mGpio = wd[7:0];
          default: ;
        endcase
      end
    end
    if (match) mPend = 1'b1;
    mCycle = mCycle + 32'd1;
  endtask

  // One bus cycle: drive after the edge, check at the falling edge, advance model at the edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd, input logic we,
                               input logic rdy, input string tag);
    bus.adr       = a;
    bus.writedata = wd;
    bus.memwrite  = we;
    bus.tx_ready  = rdy;
    @(negedge clk);
    if (modelKnown(a)) checkOutput({tag, ".rd"}, bus.readdata, modelRead(a));
    checkOutput({tag, ".valid"}, {31'b0, bus.tx_valid}, {31'b0, (mQ.size() != 0)});
    if (mQ.size() != 0) checkOutput({tag, ".data"}, {24'b0, bus.tx_data}, {24'b0, mQ[0]});
    checkOutput({tag, ".gpio"}, {24'b0, bus.gpio_out}, {24'b0, mGpio});
    checkOutput({tag, ".irq"}, {31'b0, bus.irq}, {31'b0, (mEn & mPend)});
    @(posedge clk);
    modelEdge(a, wd, we, rdy);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] target;
    logic [2:0]  idx;
    logic        we;
    logic        rdy;

    bus.adr       = 32'h8000_0008;
    bus.writedata = '0;
    bus.memwrite  = 1'b0;
    bus.tx_ready  = 1'b0;
    modelReset();

    // Reset state while reset is still held.
    #12;
    checkOutput("reset.cycle", bus.readdata, 32'd0);
    checkOutput("reset.valid", {31'b0, bus.tx_valid}, 32'd0);
    checkOutput("reset.gpio", {24'b0, bus.gpio_out}, 32'd0);
    checkOutput("reset.irq", {31'b0, bus.irq}, 32'd0);
    bus.adr = 32'h8000_0004;
    #1;
    checkOutput("reset.status", bus.readdata, 32'h1);
    @(posedge clk);
    #1 reset = 1'b0;

    // RAM store, old value during the store cycle, readback and alias.
    applyStimulus(32'h0000_0054, 32'h1111_1111, 1'b1, 1'b0, "ram.pre");
    applyStimulus(32'h0000_0054, 32'hDEAD_BEEF, 1'b1, 1'b0, "ram.store");
    applyStimulus(32'h0000_0054, 32'h0, 1'b0, 1'b0, "ram.read");
    checkOutput("ram.read_const", bus.readdata, 32'hDEAD_BEEF);
    bus.adr = 32'h0000_0154;
    #1;
    checkOutput("ram.alias_const", bus.readdata, 32'hDEAD_BEEF);
    applyStimulus(32'h0000_0154, 32'h0, 1'b0, 1'b0, "ram.alias");

    // Random RAM traffic with random alias bits.
    for (int i = 0; i < 24; i++) begin
      r  = $urandom();
      a  = {1'b0, r[30:0]};
      we = 1'($urandom_range(0, 1));
      applyStimulus(a, $urandom(), we, 1'b0, "ram.rand");
    end

    // Fill past full with the consumer stalled.
    for (int i = 0; i < 5; i++) applyStimulus(32'h8000_0000, 32'h41 + i, 1'b1, 1'b0, "fifo.push");
    applyStimulus(32'h8000_0004, 32'h0, 1'b0, 1'b0, "fifo.status");
    checkOutput("fifo.status_full_ovf", bus.readdata, 32'h6);
    for (int i = 0; i < 6; i++) applyStimulus(32'h8000_0004, 32'h0, 1'b0, 1'b1, "fifo.drain");
    checkOutput("fifo.status_empty_ovf", bus.readdata, 32'h5);
    checkOutput("fifo.valid_low", {31'b0, bus.tx_valid}, 32'd0);
    applyStimulus(32'h8000_0004, 32'h0, 1'b1, 1'b0, "fifo.clr");
    checkOutput("fifo.status_cleared", bus.readdata, 32'h1);

    // Push into a full FIFO while popping.
    for (int i = 0; i < 4; i++) applyStimulus(32'h8000_0000, 32'h61 + i, 1'b1, 1'b0, "full.push");
    applyStimulus(32'h8000_0000, 32'h55, 1'b1, 1'b1, "full.pushpop");
    bus.adr = 32'h8000_0004;
    bus.memwrite = 1'b0;
    #1;
    checkOutput("full.status", bus.readdata, 32'h2);
    checkOutput("full.head", {24'b0, bus.tx_data}, 32'h62);
    for (int i = 0; i < 5; i++) applyStimulus(32'h8000_0004, 32'h0, 1'b0, 1'b1, "full.drain");

    // Random MMIO traffic across the whole window.
    for (int i = 0; i < 60; i++) begin
      r   = $urandom();
      idx = 3'($urandom_range(0, 7));
      a   = {1'b1, r[30:5], idx, r[1:0]};
      we  = 1'($urandom_range(0, 1));
      rdy = 1'($urandom_range(0, 1));
      applyStimulus(a, $urandom(), we, rdy, "mmio.rand");
    end
    for (int i = 0; i < 5; i++) applyStimulus(32'h8000_0004, 32'h0, 1'b0, 1'b1, "mmio.flush");
    applyStimulus(32'h8000_0004, 32'h0, 1'b1, 1'b0, "mmio.clrovf");

    // GPIO and read-only CYCLE.
    applyStimulus(32'h8000_0014, 32'h1234_56A5, 1'b1, 1'b0, "gpio.wr");
    checkOutput("gpio.pin", {24'b0, bus.gpio_out}, 32'hA5);
    applyStimulus(32'h8000_0014, 32'h0, 1'b0, 1'b0, "gpio.rd");
    applyStimulus(32'h8000_0008, 32'h0, 1'b1, 1'b0, "cycle.wr");
    applyStimulus(32'h8000_0008, 32'h0, 1'b0, 1'b0, "cycle.rd");

`ifdef MMIO_TIMER_EN
    // First match raises irq one edge after CYCLE==TIMER_CMP.
    target = mCycle + 32'd8;
    applyStimulus(32'h8000_0010, 32'h2, 1'b1, 1'b0, "tmr.clear");
    applyStimulus(32'h8000_000C, target, 1'b1, 1'b0, "tmr.cmp");
    applyStimulus(32'h8000_0010, 32'h1, 1'b1, 1'b0, "tmr.en");
    for (int i = 0; i < 10; i++) applyStimulus(32'h8000_0010, 32'h0, 1'b0, 1'b0, "tmr.wait");
    checkOutput("tmr.irq_high", {31'b0, bus.irq}, 32'd1);
    // Second match coinciding with a write-1-to-clear keeps PEND set.
    target = mCycle + 32'd5;
    applyStimulus(32'h8000_000C, target, 1'b1, 1'b0, "tmr.cmp2");
    applyStimulus(32'h8000_0010, 32'h3, 1'b1, 1'b0, "tmr.w1c");
    for (int i = 0; i < 10 && mCycle != target; i++)
      applyStimulus(32'h8000_0010, 32'h0, 1'b0, 1'b0, "tmr.wait2");
    applyStimulus(32'h8000_0010, 32'h3, 1'b1, 1'b0, "tmr.setwins");
    checkOutput("tmr.setwins_irq", {31'b0, bus.irq}, 32'd1);
    applyStimulus(32'h8000_0010, 32'h0, 1'b1, 1'b0, "tmr.dis");
    checkOutput("tmr.pend_kept", bus.readdata, 32'h2);
    checkOutput("tmr.irq_masked", {31'b0, bus.irq}, 32'd0);
    applyStimulus(32'h8000_0010, 32'h1, 1'b1, 1'b0, "tmr.reen");
`else
    applyStimulus(32'h8000_000C, 32'h0000_FFFF, 1'b1, 1'b0, "notmr.cmp_wr");
    applyStimulus(32'h8000_0010, 32'h3, 1'b1, 1'b0, "notmr.ctrl_wr");
    applyStimulus(32'h8000_000C, 32'h0, 1'b0, 1'b0, "notmr.cmp_rd");
    checkOutput("notmr.cmp_zero", bus.readdata, 32'd0);
    checkOutput("notmr.irq_low", {31'b0, bus.irq}, 32'd0);
`endif

    // Reset mid-operation with bytes queued and GPIO set.
    for (int i = 0; i < 3; i++) applyStimulus(32'h8000_0000, 32'h71 + i, 1'b1, 1'b0, "rst.push");
    applyStimulus(32'h8000_0014, 32'hA5, 1'b1, 1'b0, "rst.gpio");
    bus.memwrite = 1'b0;
    bus.adr      = 32'h8000_0004;
    #2 reset = 1'b1;
    #1;
    checkOutput("rst.valid_async", {31'b0, bus.tx_valid}, 32'd0);
    checkOutput("rst.gpio_async", {24'b0, bus.gpio_out}, 32'd0);
    checkOutput("rst.irq_async", {31'b0, bus.irq}, 32'd0);
    checkOutput("rst.status_async", bus.readdata, 32'h1);
    @(posedge clk);
    #1 reset = 1'b0;
    modelReset();
    bus.adr = 32'h8000_0008;
    #1;
    checkOutput("rst.cycle_zero", bus.readdata, 32'd0);
    applyStimulus(32'h8000_0008, 32'h0, 1'b0, 1'b0, "rst.cycle");
    applyStimulus(32'h0000_0054, 32'h0, 1'b0, 1'b0, "rst.ram");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
